// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences XM23 PC redirects (LR link-back and taken branch).
// Arbitrates the two execute-stage requests, issues a one-cycle PC load and
// holds a flush for FLUSH_CYCLES unstalled cycles. Requests seen while stalled
// are deferred; requests arriving during LOAD/FLUSH belong to squashed work.
// Optional: define REDIRECT_STATS_EN to add saturating per-type redirect counters.
module pc_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned AW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          link_back_i,
  input  logic [AW-1:0] lr_i,
  input  logic          branch_req_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          stall_i,
  output logic          pc_load_o,
  output logic [AW-1:0] pc_target_o,
  output logic          flush_o,
  output logic          busy_o
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0]   link_cnt_o,
  output logic [15:0]   branch_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, LOAD, FLUSH} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [AW-1:0] target_n;
`ifdef REDIRECT_STATS_EN
  logic          is_link, is_link_n;
`endif

  // Next-state, flush counter and target selection.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    target_n = pc_target_o;
`ifdef REDIRECT_STATS_EN
    is_link_n = is_link;
`endif
    case (state)
      IDLE: begin
        if (link_back_i || branch_req_i) begin
          // link-back wins; a simultaneous branch is simply discarded
          target_n = link_back_i ? {lr_i[AW-1:1], 1'b0}
                                 : {branch_target_i[AW-1:1], 1'b0};
`ifdef REDIRECT_STATS_EN
          is_link_n = link_back_i;
`endif
          state_n = stall_i ? PEND : LOAD;
        end
      end
      PEND: begin
        if (!stall_i) state_n = LOAD;
      end
      LOAD: begin
        cnt_n   = CNT_INIT;
        state_n = (FLUSH_CYCLES <= 1) ? IDLE : FLUSH;
      end
      FLUSH: begin
        if (!stall_i) begin
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; outputs are registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pc_target_o <= '0;
      pc_load_o   <= 1'b0;
      flush_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc_target_o <= target_n;
      pc_load_o   <= (state_n == LOAD);
      flush_o     <= (state_n == LOAD) || (state_n == FLUSH);
      busy_o      <= (state_n != IDLE);
    end
  end

`ifdef REDIRECT_STATS_EN
  // Per-type redirect counters, bumped once per serviced redirect, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_link      <= 1'b0;
      link_cnt_o   <= '0;
      branch_cnt_o <= '0;
    end else begin
      is_link <= is_link_n;
      if (state == LOAD) begin
        if (is_link) begin
          if (link_cnt_o != '1) link_cnt_o <= link_cnt_o + 16'd1;
        end else begin
          if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Testbench for pc_redirect_ctrl: two instances (FLUSH_CYCLES=2 and 3) share
// stimulus; each is compared every cycle against a cycle-level reference model.
module tb_pc_redirect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, link_back, branch_req, stall;
  logic [15:0] lr, branch_target;
  logic        pc_load [2];
  logic        flush   [2];
  logic        busy    [2];
  logic [15:0] pc_target [2];
`ifdef REDIRECT_STATS_EN
  logic [15:0] link_cnt   [2];
  logic [15:0] branch_cnt [2];
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .AW(16)) u_dut2 (
    .clk(clk), .rst(rst), .link_back_i(link_back), .lr_i(lr),
    .branch_req_i(branch_req), .branch_target_i(branch_target), .stall_i(stall),
    .pc_load_o(pc_load[0]), .pc_target_o(pc_target[0]), .flush_o(flush[0]),
    .busy_o(busy[0])
`ifdef REDIRECT_STATS_EN
    , .link_cnt_o(link_cnt[0]), .branch_cnt_o(branch_cnt[0])
`endif
  );

  pc_redirect_ctrl #(.FLUSH_CYCLES(3), .AW(16)) u_dut3 (
    .clk(clk), .rst(rst), .link_back_i(link_back), .lr_i(lr),
    .branch_req_i(branch_req), .branch_target_i(branch_target), .stall_i(stall),
    .pc_load_o(pc_load[1]), .pc_target_o(pc_target[1]), .flush_o(flush[1]),
    .busy_o(busy[1])
`ifdef REDIRECT_STATS_EN
    , .link_cnt_o(link_cnt[1]), .branch_cnt_o(branch_cnt[1])
`endif
  );

  // Reference model: a redirect owes a number of unstalled flush cycles
  // (the load cycle always pays one); a stalled request waits before loading.
  int unsigned fc [2] = '{2, 3};
  bit          m_wait [2];
  bit          m_load [2];
  bit          m_link [2];
  int unsigned m_owed [2];
  logic [15:0] m_target [2];
  int unsigned m_lcnt [2];
  int unsigned m_bcnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input int k);
    if (rst) begin
      m_wait[k] = 0; m_load[k] = 0; m_link[k] = 0; m_owed[k] = 0;
      m_target[k] = '0; m_lcnt[k] = 0; m_bcnt[k] = 0;
    end else if (m_load[k]) begin
      if (m_link[k]) begin
        if (m_lcnt[k] < 32'hFFFF) m_lcnt[k]++;
      end else begin
        if (m_bcnt[k] < 32'hFFFF) m_bcnt[k]++;
      end
      m_load[k] = 0;
      m_owed[k]--;
    end else if (m_wait[k]) begin
      if (!stall) begin
        m_wait[k] = 0; m_load[k] = 1; m_owed[k] = fc[k];
      end
    end else if (m_owed[k] > 0) begin
      if (!stall) m_owed[k]--;
    end else if (link_back || branch_req) begin
      m_link[k]   = link_back;
      m_target[k] = (link_back ? lr : branch_target) & 16'hFFFE;
      if (stall) m_wait[k] = 1;
      else begin
        m_load[k] = 1; m_owed[k] = fc[k];
      end
    end
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pc_load[%0d]", k), 32'(pc_load[k]), 32'(m_load[k]));
      check($sformatf("flush[%0d]", k), 32'(flush[k]), 32'((m_owed[k] > 0) && !m_wait[k]));
      check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_wait[k] || (m_owed[k] > 0)));
      check($sformatf("pc_target[%0d]", k), 32'(pc_target[k]), 32'(m_target[k]));
`ifdef REDIRECT_STATS_EN
      check($sformatf("link_cnt[%0d]", k), 32'(link_cnt[k]), m_lcnt[k]);
      check($sformatf("branch_cnt[%0d]", k), 32'(branch_cnt[k]), m_bcnt[k]);
`endif
    end
  endtask

  task automatic step(input bit r, input bit lb, input logic [15:0] l,
                      input bit br, input logic [15:0] bt, input bit st);
    rst = r; link_back = lb; lr = l; branch_req = br; branch_target = bt; stall = st;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  initial begin
    rst = 1'b1; link_back = 1'b0; lr = '0; branch_req = 1'b0;
    branch_target = '0; stall = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0, 16'h0, 0);
    check("reset_busy", 32'(busy[0]), 32'd0);

    // branch only, odd target gets aligned
    step(0, 0, 16'h0, 1, 16'h1235, 0);
    check("branch_target", 32'(pc_target[0]), 32'h1234);
    check("branch_load", 32'(pc_load[0]), 32'd1);
    idle(4);

    // link-back
    step(0, 1, 16'h0400, 0, 16'h0, 0);
    idle(4);

    // simultaneous: link-back wins
    step(0, 1, 16'h0200, 1, 16'h0800, 0);
    check("simul_target", 32'(pc_target[1]), 32'h0200);
    idle(5);

    // stalled request; second request while pending is dropped
    step(0, 0, 16'h0, 1, 16'h0040, 1);
    step(0, 0, 16'h0, 1, 16'h0080, 1);
    step(0, 0, 16'h0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0, 16'h0, 0);
    check("stall_load_target", 32'(pc_target[0]), 32'h0040);
    idle(5);

    // flush hold with stalls and a dropped branch during FLUSH
    step(0, 0, 16'h0, 1, 16'h1000, 0);
    step(0, 0, 16'h0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 1, 16'h2000, 1);
    step(0, 0, 16'h0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1, 16'h3000, 0);
    idle(5);

    // reset mid-flush, then a fresh request
    step(0, 1, 16'h0ABC, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0, 16'h0, 0);
    check("rst_flush", 32'(flush[1]), 32'd0);
    step(0, 0, 16'h0, 1, 16'h0556, 0);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 4) == 0), 16'($urandom),
           ($urandom_range(0, 2) == 0));
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
